// File: rtl/bram_stream_dma.sv
// Moves a block of words between a simple-dual-port BRAM and a valid/ready stream.
//   clock, reset                          : single clock, synchronous active-high reset
//   start, op, base_addr, count           : transfer request, sampled in IDLE (op 0 = LOAD, 1 = DUMP)
//   in_valid/in_ready/in_data             : LOAD stream sink, written straight into the BRAM
//   out_valid/out_ready/out_data          : DUMP stream source, fed from a 2-entry FIFO
//   bram_wen/bram_waddr/bram_din          : BRAM write port (combinational from the LOAD handshake)
//   bram_raddr/bram_dout                  : BRAM read port, dout valid one cycle after raddr
//   busy, done                            : busy while not IDLE, one-cycle completion pulse
module bram_stream_dma #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ADDRESS_WIDTH = 11
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     op,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [ADDRESS_WIDTH:0]   count,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     bram_wen,
    output logic [ADDRESS_WIDTH-1:0] bram_waddr,
    output logic [DATA_WIDTH-1:0]    bram_din,
    output logic [ADDRESS_WIDTH-1:0] bram_raddr,
    input  logic [DATA_WIDTH-1:0]    bram_dout,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned CW = ADDRESS_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DUMP, S_FINISH} state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [ADDRESS_WIDTH-1:0] raddr_q, raddr_d;
    logic [CW-1:0]            rem_q, rem_d;     // words still to write (LOAD) or to emit (DUMP)
    logic [CW-1:0]            iss_q, iss_d;     // BRAM reads still to issue (DUMP)
    logic                     inflight_q, inflight_d;
    logic [1:0]               occ_q, occ_d;
    logic [DATA_WIDTH-1:0]    head_q, head_d;
    logic [DATA_WIDTH-1:0]    tail_q, tail_d;

    logic wr_c, issue_c, pop_c, push_c, ld_ready_c;

    // State register and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            raddr_q    <= '0;
            rem_q      <= '0;
            iss_q      <= '0;
            inflight_q <= 1'b0;
            occ_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            raddr_q    <= raddr_d;
            rem_q      <= rem_d;
            iss_q      <= iss_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Next-state, handshakes and FIFO update
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        raddr_d    = raddr_q;
        rem_d      = rem_q;
        iss_d      = iss_q;
        inflight_d = 1'b0;
        occ_d      = occ_q;
        head_d     = head_q;
        tail_d     = tail_q;
        wr_c       = 1'b0;
        issue_c    = 1'b0;
        pop_c      = 1'b0;
        push_c     = 1'b0;
        ld_ready_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d = base_addr;
                    rem_d  = count;
                    iss_d  = count;
                    if (count == '0) state_d = S_FINISH;
                    else if (op)     state_d = S_DUMP;
                    else             state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                ld_ready_c = 1'b1;
                if (in_valid) begin
                    wr_c   = 1'b1;
                    addr_d = addr_q + ADDRESS_WIDTH'(1);
                    rem_d  = rem_q - CW'(1);
                    if (rem_q == CW'(1)) state_d = S_FINISH;
                end
            end
            S_DUMP: begin
                pop_c  = (occ_q != 2'd0) && out_ready;
                push_c = inflight_q;
                // Issue only if the word will have a FIFO slot when it lands next cycle
                issue_c = (iss_q != '0) &&
                          (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_c}));
                if (issue_c) begin
                    raddr_d = addr_q;
                    addr_d  = addr_q + ADDRESS_WIDTH'(1);
                    iss_d   = iss_q - CW'(1);
                end
                inflight_d = issue_c;
                case ({push_c, pop_c})
                    2'b10: begin
                        if (occ_q == 2'd0) head_d = bram_dout;
                        else               tail_d = bram_dout;
                        occ_d = occ_q + 2'd1;
                    end
                    2'b01: begin
                        head_d = tail_q;
                        occ_d  = occ_q - 2'd1;
                    end
                    2'b11: begin
                        if (occ_q == 2'd1) begin
                            head_d = bram_dout;
                        end else begin
                            head_d = tail_q;
                            tail_d = bram_dout;
                        end
                    end
                    default: ;
                endcase
                if (pop_c) begin
                    rem_d = rem_q - CW'(1);
                    if (rem_q == CW'(1)) state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is high so an aborted transfer cannot write
    assign busy       = !reset && (state_q != S_IDLE);
    assign done       = !reset && (state_q == S_FINISH);
    assign in_ready   = !reset && ld_ready_c;
    assign bram_wen   = !reset && wr_c;
    assign bram_waddr = reset ? '0 : addr_q;
    assign bram_din   = in_data;
    assign bram_raddr = reset ? '0 : (issue_c ? addr_q : raddr_q);
    assign out_valid  = !reset && (occ_q != 2'd0);
    assign out_data   = head_q;

endmodule

// File: tb/tb_bram_stream_dma.sv
// Scoreboard bench for bram_stream_dma with a behavioural BRAM attached.
module tb_bram_stream_dma;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 11;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          op_s;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          bram_wen;
    logic [AW-1:0] bram_waddr;
    logic [DW-1:0] bram_din;
    logic [AW-1:0] bram_raddr;
    logic [DW-1:0] bram_dout;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [AW+DW-1:0] exp_wr[$];   // {addr, data}
    logic [DW-1:0]    exp_out[$];
    logic [DW-1:0]    mem [0:(1<<AW)-1];

    bram_stream_dma #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op_s),
        .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .bram_wen(bram_wen), .bram_waddr(bram_waddr), .bram_din(bram_din),
        .bram_raddr(bram_raddr), .bram_dout(bram_dout),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bram_wen) mem[bram_waddr] <= bram_din;
        bram_dout <= mem[bram_raddr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write and every presented output word is checked against the queues
    always @(negedge clock) begin
        if (done) done_cnt++;
        if (bram_wen) begin
            if (exp_wr.size() == 0) chk("unexpected_write", 32'(bram_waddr), 32'hFFFF_FFFF);
            else begin
                chk("write_addr", 32'(bram_waddr), 32'(exp_wr[0][AW+DW-1:DW]));
                chk("write_data", 32'(bram_din), 32'(exp_wr[0][DW-1:0]));
                void'(exp_wr.pop_front());
            end
        end
        if (out_valid) begin
            if (exp_out.size() == 0) chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
            else begin
                chk("out_data", 32'(out_data), 32'(exp_out[0]));
                if (out_ready) void'(exp_out.pop_front());
            end
        end
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic o, input logic [AW-1:0] b, input logic [AW:0] c);
        start = 1'b1; op_s = o; base_addr = b; count = c;
        step();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input bit gap);
        in_valid = 1'b1; in_data = d;
        step();
        in_valid = 1'b0;
        if (gap) step();
    endtask

    task automatic wait_done(input string name, input int max);
        for (int i = 0; i < max; i++) begin
            if (done) break;
            step();
        end
        chk(name, 32'(done), 32'd1);
    endtask

    function automatic logic [26:0] quiet_vec();
        return {busy, done, in_ready, out_valid, bram_wen, bram_raddr, bram_waddr};
    endfunction

    logic [DW-1:0] ld[4];
    logic [15:0]   pat;
    int            d0;

    initial begin
        reset = 1'b1; start = 1'b0; op_s = 1'b0; base_addr = '0; count = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        ld[0] = 16'hAAAA; ld[1] = 16'hBBBB; ld[2] = 16'hCCCC; ld[3] = 16'hDDDD;
        pat = 16'b1011_0010_1110_0101;

        // Reset behaviour
        step();
        chk("reset_outputs", 32'(quiet_vec()), 32'd0);
        step();
        reset = 1'b0;
        chk("post_reset_outputs", 32'(quiet_vec()), 32'd0);
        step();

        // LOAD with gaps across the top-of-memory wrap
        exp_wr.push_back({11'h7FE, ld[0]});
        exp_wr.push_back({11'h7FF, ld[1]});
        exp_wr.push_back({11'h000, ld[2]});
        exp_wr.push_back({11'h001, ld[3]});
        d0 = done_cnt;
        do_start(1'b0, 11'h7FE, 12'd4);
        chk("load_in_ready", 32'(in_ready), 32'd1);
        step();
        send_word(ld[0], 1'b1);
        send_word(ld[1], 1'b1);
        send_word(ld[2], 1'b1);
        send_word(ld[3], 1'b0);
        chk("load_done_pulse", 32'(done), 32'd1);
        step();
        chk("load_done_clear", 32'({done, busy, in_ready}), 32'd0);
        chk("load_done_count", 32'(done_cnt - d0), 32'd1);
        chk("load_writes_left", 32'(exp_wr.size()), 32'd0);

        // DUMP of the same four words with out_ready held high
        for (int i = 0; i < 4; i++) exp_out.push_back(ld[i]);
        out_ready = 1'b1;
        d0 = done_cnt;
        do_start(1'b1, 11'h7FE, 12'd4);
        for (int k = 0; k < 6; k++) begin
            chk("dump_latency_valid", 32'(out_valid), (k >= 2) ? 32'd1 : 32'd0);
            step();
        end
        chk("dump_done_pulse", 32'(done), 32'd1);
        step();
        chk("dump_done_count", 32'(done_cnt - d0), 32'd1);
        chk("dump_outs_left", 32'(exp_out.size()), 32'd0);

        // Eight-word load then DUMP with a stalling consumer
        for (int i = 0; i < 8; i++) exp_wr.push_back({11'h100 + 11'(i), 16'h1000 + 16'(i * 16'h0111)});
        do_start(1'b0, 11'h100, 12'd8);
        for (int i = 0; i < 8; i++) send_word(16'h1000 + 16'(i * 16'h0111), 1'b0);
        chk("load8_done", 32'(done), 32'd1);
        step();
        for (int i = 0; i < 8; i++) exp_out.push_back(16'h1000 + 16'(i * 16'h0111));
        d0 = done_cnt;
        out_ready = 1'b0;
        do_start(1'b1, 11'h100, 12'd8);
        for (int i = 0; i < 80; i++) begin
            if (done) break;
            out_ready = pat[i % 16];
            step();
        end
        chk("stall_dump_done", 32'(done), 32'd1);
        out_ready = 1'b1;
        step();
        chk("stall_dump_outs_left", 32'(exp_out.size()), 32'd0);
        chk("stall_dump_done_count", 32'(done_cnt - d0), 32'd1);

        // Zero-length transfers for both directions
        for (int o = 0; o < 2; o++) begin
            in_valid = 1'b1; in_data = 16'hDEAD;
            do_start(1'(o), 11'h055, 12'd0);
            chk("zero_len_done", 32'(done), 32'd1);
            step();
            in_valid = 1'b0;
            chk("zero_len_idle", 32'({done, busy, out_valid}), 32'd0);
        end

        // Reset after two of five LOAD words
        exp_wr.push_back({11'h200, 16'h5001});
        exp_wr.push_back({11'h201, 16'h5002});
        d0 = done_cnt;
        do_start(1'b0, 11'h200, 12'd5);
        send_word(16'h5001, 1'b0);
        send_word(16'h5002, 1'b0);
        in_valid = 1'b1; in_data = 16'h5003;
        reset = 1'b1;
        #1;
        chk("midreset_outputs", 32'(quiet_vec()), 32'd0);
        step();
        reset = 1'b0;
        chk("after_reset_busy", 32'({busy, in_ready, bram_wen}), 32'd0);
        step();
        in_valid = 1'b0;
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_writes_left", 32'(exp_wr.size()), 32'd0);
        exp_wr.push_back({11'h300, 16'hBEEF});
        do_start(1'b0, 11'h300, 12'd1);
        send_word(16'hBEEF, 1'b0);
        chk("restart_done", 32'(done), 32'd1);
        step();

        // Start pulsed while a DUMP is running
        for (int i = 0; i < 8; i++) exp_out.push_back(16'h1000 + 16'(i * 16'h0111));
        d0 = done_cnt;
        do_start(1'b1, 11'h100, 12'd8);
        step();
        step();
        start = 1'b1; op_s = 1'b0; base_addr = 11'h000; count = 12'd3;
        step();
        start = 1'b0;
        wait_done("ignored_start_done", 40);
        step();
        chk("ignored_start_outs_left", 32'(exp_out.size()), 32'd0);
        chk("ignored_start_done_count", 32'(done_cnt - d0), 32'd1);
        chk("ignored_start_idle", 32'({busy, out_valid}), 32'd0);

        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_stream_dma.md
BRAM_STREAM_DMA -- requirements
Module: bram_stream_dma

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the word width, which matches the attached BRAM.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 11, giving the BRAM address width (memory depth 2^ADDRESS_WIDTH).
REQ-003 Port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 Port start, input, 1 bit: begins a transfer; sampled only in IDLE.
REQ-006 Port op, input, 1 bit: 0 = LOAD (stream to BRAM), 1 = DUMP (BRAM to stream); sampled with start.
REQ-007 Port base_addr, input, ADDRESS_WIDTH bits: first BRAM address; sampled with start.
REQ-008 Port count, input, ADDRESS_WIDTH+1 bits: number of words, 0 to 2^ADDRESS_WIDTH; sampled with start.
REQ-009 Port in_valid / in_ready / in_data, input / output / input, 1 / 1 / DATA_WIDTH bits: LOAD stream.
REQ-010 Port out_valid / out_ready / out_data, output / input / output, 1 / 1 / DATA_WIDTH bits: DUMP stream.
REQ-011 Port bram_wen / bram_waddr / bram_din, output, 1 / ADDRESS_WIDTH / DATA_WIDTH bits: BRAM write port.
REQ-012 Port bram_raddr / bram_dout, output / input, ADDRESS_WIDTH / DATA_WIDTH bits: BRAM read port; dout valid exactly 1 cycle after raddr is presented.
REQ-013 Port busy / done, output, 1 bit each: busy = state is not IDLE; done = one-cycle completion pulse.

Function
REQ-014 The block SHALL implement the FSM states IDLE, LOAD, DUMP and FINISH.
REQ-015 IDLE with start=1 SHALL latch op/base_addr/count; count=0 -> FINISH; else op=0 -> LOAD, op=1 -> DUMP.
REQ-016 start asserted outside IDLE SHALL be ignored, with no effect on the current transfer.
REQ-017 In LOAD, in_ready SHALL be 1; on each in_valid&in_ready the block SHALL drive bram_wen=1, bram_din=in_data and bram_waddr=current address, combinationally in the same cycle.
REQ-018 bram_wen SHALL be 0 in every cycle that has no LOAD handshake; in_ready SHALL be 0 outside LOAD.
REQ-019 After each write, current address SHALL increment modulo 2^ADDRESS_WIDTH (wrap from max to 0) and remaining SHALL decrement; the write that brings remaining to 0 SHALL move the FSM to FINISH.
REQ-020 DUMP SHALL use a 2-entry output FIFO whose head drives out_valid/out_data, a 1-bit in-flight flag, and a read-issue counter.
REQ-021 DUMP SHALL issue a read (bram_raddr=current address, address++ with wrap, issue counter--) when issues remain and (2 - occupancy - inflight + (out_valid&out_ready)) > 0.
REQ-022 The word read SHALL be pushed into the FIFO in the cycle after issue; a push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-023 With out_ready held at 1, DUMP SHALL sustain one word per cycle after a 2-cycle initial latency (start accepted at t -> first out_valid at t+2).
REQ-024 out_valid SHALL stay asserted with out_data stable until out_ready; the FIFO SHALL never overflow under any out_ready pattern.
REQ-025 DUMP SHALL move to FINISH on the handshake of the count-th output word.
REQ-026 bram_raddr SHALL hold its last value when no read is issued; it has no functional meaning outside DUMP.
REQ-027 FINISH SHALL last one cycle with done=1, then return to IDLE; done SHALL be 0 in every other cycle.
REQ-028 count=2^ADDRESS_WIDTH SHALL transfer the full memory, wrapping to base_addr.

Reset
REQ-029 While reset=1 at a clock edge, the block SHALL enter IDLE and clear the FIFO, inflight flag and counters.
REQ-030 During reset and in the following cycle, outputs SHALL be busy=0, done=0, in_ready=0, out_valid=0, bram_wen=0, bram_raddr=0, bram_waddr=0.
REQ-031 Reset mid-transfer SHALL abort the transfer with no done pulse, and no further bram_wen SHALL occur.

Verification
REQ-032 LOAD base=0x7FE count=4, data A,B,C,D with gaps in in_valid -> writes to 0x7FE,0x7FF,0x000,0x001; done pulses once, 1 cycle after the 4th write.
REQ-033 DUMP of those 4 words, out_ready=1 -> out_data A,B,C,D in consecutive cycles, starting 2 cycles after start; done follows the 4th handshake.
REQ-034 DUMP count=8 with out_ready toggling randomly -> exact in-order sequence, no drops or duplicates, out_data stable while stalled.
REQ-035 start with count=0 (either op) -> no bram_wen, no out_valid; done=1 in the cycle after start.
REQ-036 reset asserted after 2 of 5 LOAD words -> only 2 writes, no done, busy=0; a new start is then accepted normally.
REQ-037 start pulsed during an active DUMP -> ignored; original transfer completes unchanged.
